// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: boot-time check of the system-ID slave (ID word at address 0,
//   build timestamp at address 1) against build-time expected values.
// Latency: 2 + 2*READ_LATENCY cycles from accepted start to done with a zero-wait
//   slave, plus one cycle per waitrequest stall.
// Backpressure: avm_address/avm_read are held while avm_waitrequest=1; a read
//   stalled for TIMEOUT_CYCLES consecutive cycles aborts the sequence with timeout=1.
//
// Ports:
//   clock, reset               system clock, asynchronous active-high reset
//   start                      single-cycle request (ignored while busy)
//   busy, done                 sequence in progress / sequence complete (level)
//   id_match, ts_match         captured words equal EXPECTED_ID / EXPECTED_TS
//   timeout                    sequence aborted on a stalled read
//   id_value, ts_value         captured ID and timestamp words
//   avm_address, avm_read      Avalon-MM read master towards the system-ID slave
//   avm_waitrequest, avm_readdata
//
// Build option: SYSID_CHECK_RETRY_EN -- when defined, a completed sequence whose
//   words do not both match is re-run from the ID read, up to 3 retries; the final
//   attempt is reported. Timeouts are never retried. Port list is identical.

module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1417708661,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    // The stall counter is compared against the last tolerated value so the
    // abort happens in the cycle that contains the TIMEOUT_CYCLES-th stall.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] LAT     = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ID   = 3'd1,
        S_WAIT_ID = 3'd2,
        S_RD_TS   = 3'd3,
        S_WAIT_TS = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        first_q, first_d;       // high only in the first cycle after reset release
    logic [7:0]  to_cnt_q, to_cnt_d;     // consecutive waitrequest cycles in the current read
    logic [1:0]  lat_cnt_q, lat_cnt_d;   // cycles elapsed since read acceptance
    logic        done_q, done_d;
    logic        id_match_q, id_match_d;
    logic        ts_match_q, ts_match_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0]  retry_cnt_q, retry_cnt_d;
`endif

    logic start_ok;
    logic launch;
    logic abort;
    logic capture_done;
    logic id_ok;
    logic ts_ok;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b1;
            to_cnt_q    <= 8'd0;
            lat_cnt_q   <= 2'd0;
            done_q      <= 1'b0;
            id_match_q  <= 1'b0;
            ts_match_q  <= 1'b0;
            timeout_q   <= 1'b0;
            id_value_q  <= 32'd0;
            ts_value_q  <= 32'd0;
`ifdef SYSID_CHECK_RETRY_EN
            retry_cnt_q <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            to_cnt_q    <= to_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            done_q      <= done_d;
            id_match_q  <= id_match_d;
            ts_match_q  <= ts_match_d;
            timeout_q   <= timeout_d;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
`ifdef SYSID_CHECK_RETRY_EN
            retry_cnt_q <= retry_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and result logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        first_d      = 1'b0;
        to_cnt_d     = to_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        done_d       = done_q;
        id_match_d   = id_match_q;
        ts_match_d   = ts_match_q;
        timeout_d    = timeout_q;
        id_value_d   = id_value_q;
        ts_value_d   = ts_value_q;
`ifdef SYSID_CHECK_RETRY_EN
        retry_cnt_d  = retry_cnt_q;
`endif
        launch       = 1'b0;
        abort        = 1'b0;
        capture_done = 1'b0;

        // A start that lands on the first edge after reset release is dropped;
        // AUTO_START alone decides whether that edge launches a sequence.
        start_ok = start && !first_q;

        case (state_q)
            S_IDLE: begin
                launch = start_ok || (first_q && AUTO_START);
            end

            S_DONE: begin
                launch = start_ok;
            end

            S_RD_ID: begin
                if (avm_waitrequest) begin
                    if (to_cnt_q == TO_LAST) begin
                        abort = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                end else if (LAT == 2'd0) begin
                    id_value_d = avm_readdata;
                    state_d    = S_RD_TS;
                    to_cnt_d   = 8'd0;
                end else begin
                    state_d   = S_WAIT_ID;
                    lat_cnt_d = 2'd1;
                end
            end

            S_WAIT_ID: begin
                if (lat_cnt_q == LAT) begin
                    id_value_d = avm_readdata;
                    state_d    = S_RD_TS;
                    to_cnt_d   = 8'd0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            S_RD_TS: begin
                if (avm_waitrequest) begin
                    if (to_cnt_q == TO_LAST) begin
                        abort = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                end else if (LAT == 2'd0) begin
                    ts_value_d   = avm_readdata;
                    capture_done = 1'b1;
                end else begin
                    state_d   = S_WAIT_TS;
                    lat_cnt_d = 2'd1;
                end
            end

            S_WAIT_TS: begin
                if (lat_cnt_q == LAT) begin
                    ts_value_d   = avm_readdata;
                    capture_done = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Compare against the words as they will be registered, so a timestamp
        // captured in this very cycle is included.
        id_ok = (id_value_d == EXPECTED_ID);
        ts_ok = (ts_value_d == EXPECTED_TS);

        if (launch) begin
            state_d    = S_RD_ID;
            to_cnt_d   = 8'd0;
            lat_cnt_d  = 2'd0;
            done_d     = 1'b0;
            id_match_d = 1'b0;
            ts_match_d = 1'b0;
            timeout_d  = 1'b0;
            id_value_d = 32'd0;
            ts_value_d = 32'd0;
`ifdef SYSID_CHECK_RETRY_EN
            retry_cnt_d = 2'd0;
`endif
        end

        // Timeout: words not yet captured keep their cleared value of 0.
        if (abort) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            timeout_d  = 1'b1;
            id_match_d = 1'b0;
            ts_match_d = 1'b0;
        end

        if (capture_done) begin
`ifdef SYSID_CHECK_RETRY_EN
            if (!(id_ok && ts_ok) && (retry_cnt_q != 2'd3)) begin
                retry_cnt_d = retry_cnt_q + 2'd1;
                state_d     = S_RD_ID;
                to_cnt_d    = 8'd0;
                lat_cnt_d   = 2'd0;
                id_value_d  = 32'd0;
                ts_value_d  = 32'd0;
            end else begin
                state_d    = S_DONE;
                done_d     = 1'b1;
                id_match_d = id_ok;
                ts_match_d = ts_ok;
            end
`else
            state_d    = S_DONE;
            done_d     = 1'b1;
            id_match_d = id_ok;
            ts_match_d = ts_ok;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The bus strobes decode directly from the state register so an
    // asynchronous reset drops avm_read immediately.
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
        avm_address = (state_q == S_RD_TS);
    end

    assign done     = done_q;
    assign id_match = id_match_q;
    assign ts_match = ts_match_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: directed bench for sysid_check_ctrl with an in-bench
//   transaction model. Instance 0: AUTO_START=1, latency 0, timeout 16.
//   Instance 1: AUTO_START=0, latency 2, timeout 255.

module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1417708661;   // 32'h5480_8475
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;
`ifdef SYSID_CHECK_RETRY_EN
    localparam int ATTEMPTS = 4;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus, driven only from the main initial block.
    logic        rst_a[2];
    logic        start_a[2];
    logic        stuck_a[2];
    int          stall_n_a[2];
    logic [31:0] mem0_a[2];
    logic [31:0] mem1_a[2];

    // Per-instance DUT-facing signals.
    logic        busy_a[2];
    logic        done_a[2];
    logic        id_match_a[2];
    logic        ts_match_a[2];
    logic        timeout_a[2];
    logic [31:0] id_value_a[2];
    logic [31:0] ts_value_a[2];
    logic        addr_a[2];
    logic        read_a[2];
    logic        wr_a[2];
    logic [31:0] rdata_a[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = g * 2;

        sysid_check_ctrl #(
            .EXPECTED_ID   (EXP_ID),
            .EXPECTED_TS   (EXP_TS),
            .READ_LATENCY  (L),
            .TIMEOUT_CYCLES(g == 0 ? 16 : 255),
            .AUTO_START    (g == 0 ? 1'b1 : 1'b0)
        ) u_dut (
            .clock          (clk),
            .reset          (rst_a[g]),
            .start          (start_a[g]),
            .busy           (busy_a[g]),
            .done           (done_a[g]),
            .id_match       (id_match_a[g]),
            .ts_match       (ts_match_a[g]),
            .timeout        (timeout_a[g]),
            .id_value       (id_value_a[g]),
            .ts_value       (ts_value_a[g]),
            .avm_address    (addr_a[g]),
            .avm_read       (read_a[g]),
            .avm_waitrequest(wr_a[g]),
            .avm_readdata   (rdata_a[g])
        );

        // Slave model: stalls address-1 reads for stall_n_a cycles in total
        // (or everything while stuck); readdata is valid only in the cycle the
        // latency rule says it must be sampled, otherwise JUNK.
        int   consumed = 0;
        logic p1_v = 1'b0, p2_v = 1'b0, p1_a = 1'b0, p2_a = 1'b0;
        logic wr;
        logic [31:0] rd;

        always_comb begin
            wr = stuck_a[g] || (read_a[g] && addr_a[g] && (consumed < stall_n_a[g]));
            if (L == 0) begin
                rd = (read_a[g] && !wr) ? (addr_a[g] ? mem1_a[g] : mem0_a[g]) : JUNK;
            end else begin
                rd = p2_v ? (p2_a ? mem1_a[g] : mem0_a[g]) : JUNK;
            end
        end

        always @(posedge clk) begin
            if (read_a[g] && addr_a[g] && (consumed < stall_n_a[g])) consumed <= consumed + 1;
            p1_v <= read_a[g] && !wr;
            p1_a <= addr_a[g];
            p2_v <= p1_v;
            p2_a <= p1_a;
        end

        assign wr_a[g]    = wr;
        assign rdata_a[g] = rd;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    endtask

    // Transaction-level model state.
    logic        p_busy[2], p_done[2], p_read[2], p_wr[2], p_addr[2];
    logic [31:0] m_id[2], m_ts[2];
    logic        m_to[2];
    int          run[2], acc0[2], rd0cyc[2], rd1cyc[2];

    // Every cycle: busy/done exclusive, request held while stalled; on each
    // completion: captured words, timeout and match flags from the model.
    task automatic monitor();
        for (int g = 0; g < 2; g++) begin
            p_busy[g] = 0; p_done[g] = 0; p_read[g] = 0; p_wr[g] = 0; p_addr[g] = 0;
            m_id[g] = 0; m_ts[g] = 0; m_to[g] = 0;
            run[g] = 0; acc0[g] = 0; rd0cyc[g] = 0; rd1cyc[g] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                int to_lim;
                to_lim = (g == 0) ? 16 : 255;
                if (busy_a[g] && !p_busy[g]) begin
                    m_id[g] = 0; m_ts[g] = 0; m_to[g] = 0; run[g] = 0;
                end
                if (read_a[g] && !wr_a[g]) begin
                    if (addr_a[g]) m_ts[g] = mem1_a[g];
                    else begin
                        m_id[g] = mem0_a[g];
                        acc0[g]++;
                    end
                    run[g] = 0;
                end else if (read_a[g] && wr_a[g]) begin
                    run[g]++;
                    if (run[g] >= to_lim) m_to[g] = 1'b1;
                end else begin
                    run[g] = 0;
                end
                if (read_a[g] && !addr_a[g]) rd0cyc[g]++;
                if (read_a[g] && addr_a[g])  rd1cyc[g]++;

                check($sformatf("busy_done_excl%0d", g), {31'd0, busy_a[g] && done_a[g]}, 32'd0);
                if (!rst_a[g] && p_read[g] && p_wr[g] && !done_a[g]) begin
                    check($sformatf("hold_read%0d", g), {31'd0, read_a[g]}, 32'd1);
                    check($sformatf("hold_addr%0d", g), {31'd0, addr_a[g]}, {31'd0, p_addr[g]});
                end
                if (done_a[g] && !p_done[g]) begin
                    check($sformatf("mdl_id_value%0d", g), id_value_a[g], m_id[g]);
                    check($sformatf("mdl_ts_value%0d", g), ts_value_a[g], m_ts[g]);
                    check($sformatf("mdl_timeout%0d", g), {31'd0, timeout_a[g]}, {31'd0, m_to[g]});
                    check($sformatf("mdl_id_match%0d", g), {31'd0, id_match_a[g]},
                          {31'd0, !m_to[g] && (m_id[g] == EXP_ID)});
                    check($sformatf("mdl_ts_match%0d", g), {31'd0, ts_match_a[g]},
                          {31'd0, !m_to[g] && (m_ts[g] == EXP_TS)});
                end
                p_busy[g] = busy_a[g];
                p_done[g] = done_a[g];
                p_read[g] = read_a[g];
                p_wr[g]   = wr_a[g];
                p_addr[g] = addr_a[g];
            end
        end
    endtask

    // Pulse start and count negedges until done; n=1 is the negedge right after
    // the edge that samples start, so n = 1 + sequence length.
    task automatic run_seq(input int g, input int exp_n, input string name);
        int n;
        start_a[g] = 1'b1;
        @(negedge clk);
        start_a[g] = 1'b0;
        n = 1;
        while (!done_a[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_cycles"}, n, exp_n);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int a0, r0, r1, n;
        for (int g = 0; g < 2; g++) begin
            rst_a[g] = 1'b1; start_a[g] = 1'b0; stuck_a[g] = 1'b0; stall_n_a[g] = 0;
            mem0_a[g] = EXP_ID; mem1_a[g] = EXP_TS;
        end
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy_a[0]}, 32'd0);
        check("rst_done",  {31'd0, done_a[0]}, 32'd0);
        check("rst_read",  {31'd0, read_a[0]}, 32'd0);
        check("rst_addr",  {31'd0, addr_a[0]}, 32'd0);
        check("rst_idval", id_value_a[0], 32'd0);

        // Auto-start: RD_ID after edge 1, RD_TS after edge 2, DONE after edge 3.
        rst_a[0] = 1'b0;
        @(negedge clk);
        check("auto_busy", {31'd0, busy_a[0]}, 32'd1);
        check("auto_rd",   {31'd0, read_a[0]}, 32'd1);
        check("auto_a0",   {31'd0, addr_a[0]}, 32'd0);
        @(negedge clk);
        check("auto_a1",   {31'd0, addr_a[0]}, 32'd1);
        check("auto_nd",   {31'd0, done_a[0]}, 32'd0);
        @(negedge clk);
        check("auto_done",  {31'd0, done_a[0]},     32'd1);
        check("auto_busy0", {31'd0, busy_a[0]},     32'd0);
        check("auto_idm",   {31'd0, id_match_a[0]}, 32'd1);
        check("auto_tsm",   {31'd0, ts_match_a[0]}, 32'd1);
        check("auto_to",    {31'd0, timeout_a[0]},  32'd0);
        check("auto_tsval", ts_value_a[0], 32'd1417708661);

        // ID mismatch.
        mem0_a[0] = 32'h0000_0001;
        a0 = acc0[0];
        @(negedge clk);
        run_seq(0, 1 + ATTEMPTS * 2, "mism");
        check("mism_idm",   {31'd0, id_match_a[0]}, 32'd0);
        check("mism_tsm",   {31'd0, ts_match_a[0]}, 32'd1);
        check("mism_idval", id_value_a[0], 32'd1);
        check("mism_to",    {31'd0, timeout_a[0]}, 32'd0);
        check("mism_reads", acc0[0] - a0, ATTEMPTS);
        mem0_a[0] = EXP_ID;

        // Five stall cycles on the timestamp read.
        stall_n_a[0] = stall_n_a[0] + 5;
        r1 = rd1cyc[0];
        run_seq(0, 8, "stall");
        check("stall_rd1cyc", rd1cyc[0] - r1, 6);
        check("stall_idm",    {31'd0, id_match_a[0]}, 32'd1);
        check("stall_tsm",    {31'd0, ts_match_a[0]}, 32'd1);
        check("stall_tsval",  ts_value_a[0], EXP_TS);

        // Waitrequest stuck high: abort after 16 stalled ID-read cycles.
        stuck_a[0] = 1'b1;
        r0 = rd0cyc[0];
        run_seq(0, 17, "tmo");
        check("tmo_rd0cyc", rd0cyc[0] - r0, 16);
        check("tmo_flag",   {31'd0, timeout_a[0]},  32'd1);
        check("tmo_idm",    {31'd0, id_match_a[0]}, 32'd0);
        check("tmo_tsm",    {31'd0, ts_match_a[0]}, 32'd0);
        check("tmo_idval",  id_value_a[0], 32'd0);
        check("tmo_tsval",  ts_value_a[0], 32'd0);
        check("tmo_rd",     {31'd0, read_a[0]}, 32'd0);
        stuck_a[0] = 1'b0;

        // Instance 1: start coincident with reset release is ignored.
        start_a[1] = 1'b1;
        rst_a[1]   = 1'b0;
        @(negedge clk);
        start_a[1] = 1'b0;
        check("coinc_busy", {31'd0, busy_a[1]}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_busy", {31'd0, busy_a[1]}, 32'd0);
            check("idle_read", {31'd0, read_a[1]}, 32'd0);
            check("idle_done", {31'd0, done_a[1]}, 32'd0);
        end

        // Latency 2, with a start pulse while busy that must be dropped.
        a0 = acc0[1];
        r0 = rd0cyc[1];
        start_a[1] = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        n = 1;
        check("l2_rd_first", {31'd0, read_a[1]}, 32'd1);
        @(negedge clk);
        n = 2;
        check("l2_rd_drop", {31'd0, read_a[1]}, 32'd0);
        start_a[1] = 1'b1;
        @(negedge clk);
        n = 3;
        start_a[1] = 1'b0;
        while (!done_a[1] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("l2_cycles",  n, 7);
        check("l2_reads",   acc0[1] - a0, 1);
        check("l2_rd0cyc",  rd0cyc[1] - r0, 1);
        check("l2_idm",     {31'd0, id_match_a[1]}, 32'd1);
        check("l2_tsm",     {31'd0, ts_match_a[1]}, 32'd1);
        repeat (4) @(negedge clk);
        check("l2_no_rerun_done", {31'd0, done_a[1]}, 32'd1);
        check("l2_no_rerun_busy", {31'd0, busy_a[1]}, 32'd0);
        check("l2_no_rerun_rds",  acc0[1] - a0, 1);

        // Reset while the timestamp read is stalled.
        mem0_a[1]    = 32'h0000_00A5;
        stall_n_a[1] = 1000;
        start_a[1]   = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        n = 0;
        while (!(read_a[1] && addr_a[1]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_ts", {31'd0, read_a[1] && addr_a[1]}, 32'd1);
        repeat (2) @(negedge clk);
        check("mid_pre_read", {31'd0, read_a[1]}, 32'd1);
        check("mid_pre_id",   id_value_a[1], 32'h0000_00A5);
        rst_a[1] = 1'b1;
        #1;
        check("mid_rst_read", {31'd0, read_a[1]}, 32'd0);
        check("mid_rst_addr", {31'd0, addr_a[1]}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a[1]}, 32'd0);
        check("mid_rst_id",   id_value_a[1], 32'd0);
        @(negedge clk);
        rst_a[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_busy", {31'd0, busy_a[1]}, 32'd0);
            check("post_rst_read", {31'd0, read_a[1]}, 32'd0);
            check("post_rst_done", {31'd0, done_a[1]}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
